// File: rtl/tag_array_ctrl_if.sv
// Request/response bundle between the cache pipeline and the tag array controller.
// The master is the pipeline (issues requests, consumes lookup results); the
// slave is the controller.
interface tag_array_ctrl_if #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 20
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [SET_BITS-1:0] req_set;
    logic [TAG_BITS-1:0] req_tag;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_hit;
    logic [TAG_BITS-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_set, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_set, req_tag, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_tag
    );
endinterface

// File: rtl/tag_array_ctrl.sv
// Owner of the single port of the cache tag SRAM. Serialises lookup, fill and
// invalidate requests onto the port, compares returned entries against the
// requested tag, and clears the whole array after reset or on flush.
//
// state | meaning
// INIT  | sweeping sets 0..DEPTH-1, writing zero to each
// IDLE  | accepting requests; fills/invalidates complete here in one cycle
// READ  | lookup issued last edge, SRAM data returns this cycle
// RESP  | lookup result held until the consumer takes it
module tag_array_ctrl #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 20
) (
    input  logic                clk,
    input  logic                rst,
    tag_array_ctrl_if.slave     bus,
    input  logic                flush,
    output logic                busy_init,
    output logic                sram_csb,
    output logic                sram_web,
    output logic [SET_BITS-1:0] sram_addr,
    output logic [TAG_BITS:0]   sram_din,
    input  logic [TAG_BITS:0]   sram_dout
);
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;

    typedef enum logic [1:0] {INIT, IDLE, READ, RESP} state_t;

    state_t              state, state_next;
    logic [SET_BITS-1:0] cnt;
    logic [TAG_BITS-1:0] lat_tag;
    logic                hit_q;
    logic [TAG_BITS-1:0] tag_q;
    logic                accept;
    logic                is_write;

    assign accept   = (state == IDLE) && !flush && bus.req_valid;
    assign is_write = (bus.req_op == OP_FILL) || (bus.req_op == OP_INVAL);

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_hit   = hit_q;
    assign bus.resp_tag   = tag_q;

    // State register, sweep counter, latched lookup tag and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            lat_tag <= '0;
            hit_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state <= state_next;
            // Counter only runs in INIT, so it is already zero on entry from flush.
            if (state == INIT) cnt <= cnt + 1'b1;
            else               cnt <= '0;
            if (accept && !is_write) lat_tag <= bus.req_tag;
            if (state == READ) begin
                hit_q <= sram_dout[TAG_BITS] && (sram_dout[TAG_BITS-1:0] == lat_tag);
                tag_q <= sram_dout[TAG_BITS-1:0];
            end
        end
    end

    // Next state, handshake and SRAM port drive.
    always_comb begin
        state_next    = state;
        busy_init     = 1'b0;
        bus.req_ready = 1'b0;
        sram_csb      = 1'b1;
        sram_web      = 1'b1;
        sram_addr     = bus.req_set;
        sram_din      = '0;
        case (state)
            INIT: begin
                busy_init = 1'b1;
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = cnt;
                if (cnt == {SET_BITS{1'b1}}) state_next = IDLE;
            end
            IDLE: begin
                bus.req_ready = !flush;
                if (flush) begin
                    state_next = INIT;
                end else if (bus.req_valid) begin
                    sram_csb = 1'b0;
                    if (bus.req_op == OP_FILL) begin
                        sram_web = 1'b0;
                        sram_din = {1'b1, bus.req_tag};
                    end else if (bus.req_op == OP_INVAL) begin
                        sram_web = 1'b0;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: state_next = RESP;
            RESP: if (bus.resp_ready) state_next = IDLE;
            default: state_next = INIT;
        endcase
        // The SRAM must stay deselected while reset is held, whatever the state.
        if (rst) begin
            sram_csb      = 1'b1;
            sram_web      = 1'b1;
            bus.req_ready = 1'b0;
            busy_init     = 1'b1;
        end
    end
endmodule
